// File: rtl/alu_arbiter_if.sv
// Signal bundle for alu_arbiter: requester handshakes, the response bus and the ALU-side wires.
// slave is the arbiter's view; master is the environment (both requesters plus the ALU).
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             Req0, Gnt0, Done0;
  logic [WIDTH-1:0] A0, B0;
  logic [2:0]       Op0;
  logic             Req1, Gnt1, Done1;
  logic [WIDTH-1:0] A1, B1;
  logic [2:0]       Op1;
  logic [WIDTH-1:0] RspResult;
  logic             RspZ, RspV, RspC, RspErr;
  logic [WIDTH-1:0] AluA, AluB;
  logic [2:0]       AluOp;
  logic [WIDTH-1:0] AluResult;
  logic             AluZ, AluV, AluC, AluWe;

  modport slave (
    input  Req0, A0, B0, Op0, Req1, A1, B1, Op1,
    input  AluResult, AluZ, AluV, AluC, AluWe,
    output Gnt0, Done0, Gnt1, Done1,
    output RspResult, RspZ, RspV, RspC, RspErr,
    output AluA, AluB, AluOp
  );

  modport master (
    output Req0, A0, B0, Op0, Req1, A1, B1, Op1,
    output AluResult, AluZ, AluV, AluC, AluWe,
    input  Gnt0, Done0, Gnt1, Done1,
    input  RspResult, RspZ, RspV, RspC, RspErr,
    input  AluA, AluB, AluOp
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between two requesters, with a timeout abort on a missing AluWe.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round robin.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input logic          Clk,
  input logic          Reset,
  alu_arbiter_if.slave bus
);
  localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, stateNxt;
  logic [CW-1:0]    cnt, cntNxt;
  logic             ptr, ptrNxt, sel;
  logic             gnt0, gnt0Nxt, gnt1, gnt1Nxt;
  logic             done0, done0Nxt, done1, done1Nxt;
  logic [WIDTH-1:0] aluA, aluANxt, aluB, aluBNxt, res, resNxt;
  logic [2:0]       aluOp, aluOpNxt;
  logic             z, zNxt, v, vNxt, c, cNxt, err, errNxt;

  // ptr always names the current owner while an op is in flight, so Done routes from it.
  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    ptrNxt   = ptr;
    sel      = 1'b0;
    gnt0Nxt  = 1'b0;
    gnt1Nxt  = 1'b0;
    done0Nxt = 1'b0;
    done1Nxt = 1'b0;
    aluANxt  = aluA;
    aluBNxt  = aluB;
    aluOpNxt = aluOp;
    resNxt   = res;
    zNxt     = z;
    vNxt     = v;
    cNxt     = c;
    errNxt   = err;
    case (state)
      IDLE: begin
        if (bus.Req0 || bus.Req1) begin
`ifdef ARB_FIXED_PRIO_EN
          sel = ~bus.Req0;
`else
          sel = (bus.Req0 && bus.Req1) ? ~ptr : bus.Req1;
`endif
          aluANxt  = sel ? bus.A1 : bus.A0;
          aluBNxt  = sel ? bus.B1 : bus.B0;
          aluOpNxt = sel ? bus.Op1 : bus.Op0;
          gnt0Nxt  = ~sel;
          gnt1Nxt  = sel;
          ptrNxt   = sel;
          cntNxt   = '0;
          stateNxt = WAIT;
        end
      end
      WAIT: begin
        // cnt==0 is the settle cycle, so a We left over from the previous op is never taken.
        if (cnt != '0 && bus.AluWe) begin
          resNxt   = bus.AluResult;
          zNxt     = bus.AluZ;
          vNxt     = bus.AluV;
          cNxt     = bus.AluC;
          errNxt   = 1'b0;
          done0Nxt = ~ptr;
          done1Nxt = ptr;
          stateNxt = RESP;
        end else if (cnt == CNT_LAST) begin
          resNxt   = '0;
          zNxt     = 1'b0;
          vNxt     = 1'b0;
          cNxt     = 1'b0;
          errNxt   = 1'b1;
          done0Nxt = ~ptr;
          done1Nxt = ptr;
          stateNxt = RESP;
        end else begin
          cntNxt = cnt + CNT_ONE;
        end
      end
      RESP:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= 1'b1;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      aluA  <= '0;
      aluB  <= '0;
      aluOp <= '0;
      res   <= '0;
      z     <= 1'b0;
      v     <= 1'b0;
      c     <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
      ptr   <= ptrNxt;
      gnt0  <= gnt0Nxt;
      gnt1  <= gnt1Nxt;
      done0 <= done0Nxt;
      done1 <= done1Nxt;
      aluA  <= aluANxt;
      aluB  <= aluBNxt;
      aluOp <= aluOpNxt;
      res   <= resNxt;
      z     <= zNxt;
      v     <= vNxt;
      c     <= cNxt;
      err   <= errNxt;
    end
  end

  assign bus.Gnt0      = gnt0;
  assign bus.Gnt1      = gnt1;
  assign bus.Done0     = done0;
  assign bus.Done1     = done1;
  assign bus.AluA      = aluA;
  assign bus.AluB      = aluB;
  assign bus.AluOp     = aluOp;
  assign bus.RspResult = res;
  assign bus.RspZ      = z;
  assign bus.RspV      = v;
  assign bus.RspC      = c;
  assign bus.RspErr    = err;
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a configurable-latency ALU model.
// Honors ARB_FIXED_PRIO_EN in its reference arbitration rule.
module tb_alu_arbiter;
  localparam int W   = 32;
  localparam int TMO = 64;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  alu_arbiter_if #(.WIDTH(W)) bus ();
  alu_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (.Clk(Clk), .Reset(Reset), .bus(bus.slave));

  int         numChecks = 0;
  int         numErrors = 0;
  int         lastServed = 1;
  logic [W-1:0] aV[2];
  logic [W-1:0] bV[2];
  logic [2:0]   opV[2];
  int         expDone[2] = '{0, 0};
  int         seenDone[2] = '{0, 0};
  bit         overlap = 1'b0;
  int         aluMode = 0;
  int         aluLat = 1;
  int         aluCtr = 0;
  bit         aluBusy = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] aluRef(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return (b == '0) ? '0 : a % b;
    endcase
  endfunction

  // Flag order {Z,V,C}; V and C are arbitrary result bits so each flag is traceable.
  function automatic logic [2:0] flagsOf(input logic [W-1:0] r);
    return {r == '0, r[1], r[0]};
  endfunction

  // ALU model: mode 0 pulses We aluLat cycles after the operands appear, mode 1 never
  // asserts We, mode 2 holds We high with a result registered one cycle behind its inputs.
  always @(posedge Clk or posedge Reset) begin
    logic [W-1:0] r;
    if (Reset) begin
      aluBusy       <= 1'b0;
      bus.AluWe     <= 1'b0;
      bus.AluResult <= '0;
      {bus.AluZ, bus.AluV, bus.AluC} <= 3'b000;
    end else begin
      r = aluRef(bus.AluA, bus.AluB, bus.AluOp);
      case (aluMode)
        1: bus.AluWe <= 1'b0;
        2: begin
          bus.AluResult <= r;
          {bus.AluZ, bus.AluV, bus.AluC} <= flagsOf(r);
          bus.AluWe <= 1'b1;
        end
        default: begin
          bus.AluWe <= 1'b0;
          if ((aluBusy && aluCtr <= 1) || (!aluBusy && (bus.Gnt0 || bus.Gnt1) && aluLat <= 1)) begin
            bus.AluResult <= r;
            {bus.AluZ, bus.AluV, bus.AluC} <= flagsOf(r);
            bus.AluWe <= 1'b1;
            aluBusy <= 1'b0;
          end else if (aluBusy) begin
            aluCtr <= aluCtr - 1;
          end else if (bus.Gnt0 || bus.Gnt1) begin
            aluBusy <= 1'b1;
            aluCtr  <= aluLat - 1;
          end
        end
      endcase
    end
  end

  always @(negedge Clk) begin
    if (!Reset) begin
      if ((bus.Gnt0 && bus.Gnt1) || (bus.Done0 && bus.Done1)) overlap = 1'b1;
      seenDone[0] += int'(bus.Done0);
      seenDone[1] += int'(bus.Done1);
    end
  end

  task automatic applyStimulus(input int idx, input bit on, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [2:0] op);
    if (idx == 0) begin
      bus.Req0 = on; bus.A0 = a; bus.B0 = b; bus.Op0 = op;
    end else begin
      bus.Req1 = on; bus.A1 = a; bus.B1 = b; bus.Op1 = op;
    end
    aV[idx] = a; bV[idx] = b; opV[idx] = op;
  endtask

  function automatic int pickWinner();
    if (bus.Req0 && bus.Req1) begin
`ifdef ARB_FIXED_PRIO_EN
      return 0;
`else
      return (lastServed == 0) ? 1 : 0;
`endif
    end
    return bus.Req0 ? 0 : 1;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Ctl"}, 64'({bus.Gnt0, bus.Gnt1, bus.Done0, bus.Done1, bus.RspZ, bus.RspV,
                                   bus.RspC, bus.RspErr, bus.AluOp}), 64'd0);
    checkOutput({tag, "Res"}, 64'(bus.RspResult), 64'd0);
    checkOutput({tag, "AluA"}, 64'(bus.AluA), 64'd0);
    checkOutput({tag, "AluB"}, 64'(bus.AluB), 64'd0);
  endtask

  task automatic applyReset();
    Reset = 1'b1;
    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;
    repeat (2) @(negedge Clk);
    checkResetState("rst");
    Reset = 1'b0;
    lastServed = 1;
  endtask

  // Called at an IDLE negedge with requests already driven; serves exactly one op.
  task automatic serveOne(input int expLat, input bit expErr);
    int           exp, who, got, cyc;
    bit           stable;
    logic [W-1:0] expRes, holdA, holdB;
    logic [2:0]   holdOp;
    exp = pickWinner();
    who = -1;
    cyc = 0;
    while (who < 0 && cyc < 8) begin
      @(negedge Clk);
      cyc++;
      if (bus.Gnt0) who = 0;
      else if (bus.Gnt1) who = 1;
    end
    checkOutput("gntWho", 64'(who), 64'(exp));
    checkOutput("gntLat", 64'(cyc), 64'd1);
    checkOutput("aluA", 64'(bus.AluA), 64'(aV[exp]));
    checkOutput("aluB", 64'(bus.AluB), 64'(bV[exp]));
    checkOutput("aluOp", 64'(bus.AluOp), 64'(opV[exp]));
    holdA = bus.AluA; holdB = bus.AluB; holdOp = bus.AluOp;
    lastServed = exp;
    expDone[exp]++;
    if (exp == 0) bus.Req0 = 1'b0; else bus.Req1 = 1'b0;
    expRes = expErr ? '0 : aluRef(aV[exp], bV[exp], opV[exp]);
    got = -1;
    cyc = 0;
    stable = 1'b1;
    while (got < 0 && cyc < TMO + 16) begin
      @(negedge Clk);
      cyc++;
      if (bus.Done0) got = 0;
      else if (bus.Done1) got = 1;
      else if (bus.AluA !== holdA || bus.AluB !== holdB || bus.AluOp !== holdOp) stable = 1'b0;
    end
    checkOutput("doneWho", 64'(got), 64'(exp));
    checkOutput("doneLat", 64'(cyc), 64'(expLat));
    checkOutput("aluHold", 64'(stable), 64'd1);
    checkOutput("rspResult", 64'(bus.RspResult), 64'(expRes));
    checkOutput("rspFlags", 64'({bus.RspZ, bus.RspV, bus.RspC}),
                64'(expErr ? 3'b000 : flagsOf(expRes)));
    checkOutput("rspErr", 64'(bus.RspErr), 64'(expErr));
    @(negedge Clk);
    checkOutput("donePulse", 64'({bus.Done0, bus.Done1}), 64'd0);
    checkOutput("rspHeld", 64'(bus.RspResult), 64'(expRes));
  endtask

  initial begin
    int cyc;
    logic [1:0] r;
    applyStimulus(0, 1'b0, '0, '0, 3'd0);
    applyStimulus(1, 1'b0, '0, '0, 3'd0);
    applyReset();

    $display("[TB] single MOD request");
    aluMode = 0; aluLat = 1;
    applyStimulus(0, 1'b1, 32'd16, 32'd5, 3'd7);
    serveOne(2, 1'b0);
    checkOutput("noDone1", 64'(seenDone[1]), 64'd0);

    $display("[TB] simultaneous requests after reset");
    applyReset();
    applyStimulus(0, 1'b1, 32'd42, 32'd11, 3'd7);
    applyStimulus(1, 1'b1, 32'd16, 32'd5, 3'd7);
    serveOne(2, 1'b0);
    serveOne(2, 1'b0);

    $display("[TB] continuous contention");
    aluLat = 2;
    applyStimulus(0, 1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)));
    applyStimulus(1, 1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)));
    for (int i = 0; i < 4; i++) begin
      serveOne(aluLat + 1, 1'b0);
      if (!bus.Req0) applyStimulus(0, 1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)));
      if (!bus.Req1) applyStimulus(1, 1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)));
    end
    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;

    $display("[TB] randomized requests and latencies");
    for (int i = 0; i < 10; i++) begin
      aluLat = $urandom_range(1, 6);
      r = 2'($urandom_range(1, 3));
      applyStimulus(0, r[0], $urandom, $urandom, 3'($urandom_range(0, 7)));
      applyStimulus(1, r[1], $urandom, $urandom, 3'($urandom_range(0, 7)));
      serveOne(aluLat + 1, 1'b0);
    end
    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;

    $display("[TB] AluWe on the last counted cycle");
    aluLat = TMO - 1;
    applyStimulus(1, 1'b1, 32'd77, 32'd12, 3'd1);
    serveOne(TMO, 1'b0);

    $display("[TB] timeout then recovery");
    aluMode = 1;
    applyStimulus(0, 1'b1, 32'd100, 32'd3, 3'd0);
    serveOne(TMO, 1'b1);
    aluMode = 0; aluLat = 2;
    applyStimulus(0, 1'b1, 32'd100, 32'd7, 3'd7);
    serveOne(3, 1'b0);

    $display("[TB] stale AluWe held high");
    aluMode = 2;
    repeat (2) @(negedge Clk);
    applyStimulus(1, 1'b1, 32'd7, 32'd3, 3'd0);
    serveOne(2, 1'b0);
    aluMode = 0;
    @(negedge Clk);

    $display("[TB] reset during WAIT");
    aluMode = 1;
    applyStimulus(0, 1'b1, 32'd5, 32'd5, 3'd0);
    cyc = 0;
    while (!bus.Gnt0 && cyc < 8) begin
      @(negedge Clk);
      cyc++;
    end
    checkOutput("midGnt", 64'(bus.Gnt0), 64'd1);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;
    #1;
    checkResetState("async");
    @(negedge Clk);
    Reset = 1'b0;
    lastServed = 1;
    aluMode = 0; aluLat = 1;
    applyStimulus(0, 1'b1, 32'd9, 32'd4, 3'd2);
    applyStimulus(1, 1'b1, 32'd9, 32'd4, 3'd3);
    serveOne(2, 1'b0);
    serveOne(2, 1'b0);

    repeat (3) @(negedge Clk);
    checkOutput("done0Count", 64'(seenDone[0]), 64'(expDone[0]));
    checkOutput("done1Count", 64'(seenDone[1]), 64'(expDone[1]));
    checkOutput("exclusive", 64'(overlap), 64'd0);
    $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one multi-cycle ALU between two requesters (e.g. the fetch/address unit and the execute unit).
- Arbitrates the requesters and drives the ALU operand and opcode inputs.
- Waits for the ALU write-enable (We) handshake, including for multi-cycle ops such as MOD (ALUOp=7).
- Returns the result and flags to the winning requester.
- Sits between the requesters and the ALU instance, with its ALU-side ports wired directly to the ALU.

Parameters:
WIDTH, 32, operand/result width (must match ALU).
TIMEOUT, 64, max cycles to wait for AluWe before aborting the op with Err.

Ports:
Clk  in  1  clock, rising edge.
Reset  in  1  asynchronous, active-high reset.
Req0  in  1  requester 0 request; held high until Gnt0.
A0  in  WIDTH  requester 0 operand A.
B0  in  WIDTH  requester 0 operand B.
Op0  in  3  requester 0 ALUOp.
Gnt0  out  1  one-cycle grant pulse; operands latched.
Done0  out  1  one-cycle completion pulse to requester 0.
Req1/A1/B1/Op1/Gnt1/Done1  same as above, for requester 1.
RspResult  out  WIDTH  captured ALU result.
RspZ  out  1  captured ALU Z flag.
RspV  out  1  captured ALU V flag.
RspC  out  1  captured ALU C flag.
RspErr  out  1  1 = op aborted by timeout.
AluA  out  WIDTH  to ALU A.
AluB  out  WIDTH  to ALU B.
AluOp  out  3  to ALU ALUOp.
AluResult  in  WIDTH  from ALU Result.
AluZ  in  1  from ALU Z.
AluV  in  1  from ALU V.
AluC  in  1  from ALU C.
AluWe  in  1  from ALU We (result valid).

Behaviour:
- Reset (async, any state, including mid-op):
  - All outputs 0.
  - State IDLE, timeout counter 0.
  - Last-served pointer = 1, so requester 0 wins the first tie.
  - Any in-flight op is dropped; no Done is issued for it.
- All outputs are registered.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Req0/Req1 are sampled only in IDLE.
  - Only one Req high: select it.
  - Both high: select the one not equal to the last-served pointer (round robin).
  - On the selecting edge:
    - AluA/AluB/AluOp <= the selected requester's A/B/Op.
    - Gnt_sel <= 1.
    - Pointer <= sel.
    - Counter <= 0.
    - -> WAIT.
  - No Req: stay in IDLE; the Alu* outputs hold their last values.
- WAIT:
  - Gnt_sel drops after one cycle.
  - First WAIT cycle is a settle cycle: AluWe is ignored, so a stale We from the previous op is never captured.
  - From the second WAIT cycle, on AluWe=1:
    - RspResult/Z/V/C <= Alu*.
    - RspErr <= 0.
    - -> RESP.
  - Counter increments every WAIT cycle. If it reaches TIMEOUT-1 without a capture:
    - RspResult <= 0, flags <= 0, RspErr <= 1.
    - -> RESP.
  - If AluWe and the timeout occur in the same cycle, AluWe wins (valid capture).
  - Alu* outputs are held stable for the whole of WAIT.
- RESP:
  - Done_sel = 1 for exactly one cycle.
  - Rsp* values are valid that cycle and held until the next capture.
  - -> IDLE. A request pending at that point is arbitrated in the next IDLE cycle.
- Latency:
  - Req sampled at edge N -> Gnt high in cycle N+1.
  - Minimum Done at cycle N+3 (single-cycle ALU op whose We is high in the second WAIT cycle).
- Never more than one op in flight.
- Gnt0/Gnt1 and Done0/Done1 are mutually exclusive.
- Requester obligations:
  - Deassert Req in the cycle after Gnt. Req still high in IDLE is treated as a new request.
  - A/B/Op only need to be valid while Req is high.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: fixed priority; requester 0 always wins a tie; pointer unused.
- Undefined: round robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Req0 with A0=16, B0=5, Op0=7 (MOD) -> one Gnt0 pulse; AluOp=7 during WAIT; Done0 with RspResult=1, RspErr=0; Done1 never pulses.
- Req0 (42,11,MOD) and Req1 (16,5,MOD) asserted on the same edge after reset -> Gnt0 first, Done0 RspResult=9; then Gnt1, Done1 RspResult=1.
- Both requesters re-request continuously for 4 ops -> grants alternate 0,1,0,1. Under ARB_FIXED_PRIO_EN -> grants are 0,0,0,0.
- ALU model holds AluWe=0 -> Done pulses exactly TIMEOUT cycles after entering WAIT, with RspErr=1 and RspResult=0. Next op with a working ALU completes with RspErr=0.
- ALU model holds AluWe=1 from before issue, single-cycle op -> capture happens no earlier than the second WAIT cycle and returns the new op's result.
- Reset asserted mid-WAIT (async, between edges) -> all outputs 0 immediately; no Done for the dropped op; Req0 after release is served normally and wins the first tie.
